// File: rtl/comparator_pkg.sv
// Shared types for the iterative magnitude comparator: FSM state encoding,
// the gt/eq/lt cascade record and the seed value used at the start of a compare.
package comparator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cmp_state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_result_t;

  // Cascade seed: "equal so far" before any digit has been looked at.
  localparam cmp_result_t CMP_RESET_RESULT = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};

  // Value of the user-visible result before the first compare completes.
  localparam cmp_result_t CMP_CLEAR_RESULT = '{gt: 1'b0, eq: 1'b0, lt: 1'b0};

  // Digit index register width; a single-digit build still needs one bit.
  function automatic int cmp_idx_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/cmp_digit_slice.sv
// One DIGIT-bit slice of the magnitude compare. The incoming cascade carries
// the verdict of all more-significant digits; once it is no longer "equal"
// it passes through untouched, so the first difference from the MSB wins.
module cmp_digit_slice
  import comparator_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_dig,
  input  logic [DIGIT-1:0] b_dig,
  input  cmp_result_t      casc_in,
  output cmp_result_t      casc_out
);

  // Refine the cascade with this digit only while everything above was equal.
  always_comb begin
    casc_out = casc_in;
    if (casc_in.eq) begin
      if (a_dig > b_dig) begin
        casc_out = '{gt: 1'b1, eq: 1'b0, lt: 1'b0};
      end else if (a_dig < b_dig) begin
        casc_out = '{gt: 1'b0, eq: 1'b0, lt: 1'b1};
      end
    end
  end

endmodule

// File: rtl/iterative_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, one DIGIT-bit digit per cycle
// from the MSB down, with a start/busy/done handshake.
// Signed compares flip the sign bit of both latched operands so that
// two's-complement order becomes plain unsigned order.
// Optional feature: define CMP_EARLY_EXIT_EN to finish on the first
// differing digit instead of always walking all NDIG digits.
//
//   state | meaning
//   IDLE  | waiting for start; result registers hold the last verdict
//   RUN   | walking digits idx = NDIG-1 .. 0, cascade accumulating
module iterative_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NDIG  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int IDX_W = cmp_idx_width(NDIG);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  generate
    if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
      $fatal(1, "iterative_magnitude_comparator: DIGIT=%0d out of range 1..WIDTH=%0d", DIGIT, WIDTH);
    end else if ((WIDTH % DIGIT) != 0) begin : g_bad_split
      $fatal(1, "iterative_magnitude_comparator: WIDTH=%0d not a multiple of DIGIT=%0d", WIDTH, DIGIT);
    end
  endgenerate

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] a_in, b_in;
  logic [IDX_W-1:0] idx_q, idx_d;
  cmp_result_t      casc_q, casc_d;
  cmp_result_t      res_q, res_d;
  cmp_result_t      slice_res;
  logic             done_q, done_d;
  logic             finish;
  logic [DIGIT-1:0] a_dig, b_dig;

  // Map signed order onto unsigned order by inverting the sign bit of both operands.
  always_comb begin
    a_in = a;
    b_in = b;
    if (is_signed) begin
      a_in[WIDTH-1] = ~a[WIDTH-1];
      b_in[WIDTH-1] = ~b[WIDTH-1];
    end
  end

  // Digit select: a single shared slice is fed the digit addressed by idx_q.
  generate
    if (NDIG == 1) begin : g_one_digit
      assign a_dig = a_q;
      assign b_dig = b_q;
    end else begin : g_digit_mux
      logic [DIGIT-1:0] a_arr [NDIG];
      logic [DIGIT-1:0] b_arr [NDIG];
      for (genvar k = 0; k < NDIG; k++) begin : g_split
        assign a_arr[k] = a_q[k*DIGIT +: DIGIT];
        assign b_arr[k] = b_q[k*DIGIT +: DIGIT];
      end
      assign a_dig = a_arr[idx_q];
      assign b_dig = b_arr[idx_q];
    end
  endgenerate

  cmp_digit_slice #(
    .DIGIT (DIGIT)
  ) u_slice (
    .a_dig    (a_dig),
    .b_dig    (b_dig),
    .casc_in  (casc_q),
    .casc_out (slice_res)
  );

  // The run ends on the last digit, or on the first difference when early exit is built in.
  assign finish = (idx_q == '0) || (EARLY_EXIT && !slice_res.eq);

  // Next-state and datapath control; everything holds unless a transition says otherwise.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    casc_d  = casc_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          idx_d   = IDX_LAST;
          casc_d  = CMP_RESET_RESULT;
          state_d = RUN;
        end
      end
      RUN: begin
        casc_d = slice_res;
        if (finish) begin
          res_d   = slice_res;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand, index and result registers; reset aborts any compare in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      casc_q  <= CMP_RESET_RESULT;
      res_q   <= CMP_CLEAR_RESULT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      casc_q  <= casc_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign gt   = res_q.gt;
  assign eq   = res_q.eq;
  assign lt   = res_q.lt;

endmodule

// File: tb/tb_iterative_magnitude_comparator.sv
// Scoreboard bench for iterative_magnitude_comparator (WIDTH=32, DIGIT=4).
// The driver pushes {accept edge, done edge, verdict} whenever a start will be
// accepted; the monitor checks busy/done/results every cycle against the queue.
module tb_iterative_magnitude_comparator;

  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              is_signed;
  logic [WIDTH-1:0]  a, b;
  logic              busy, done, gt, eq, lt;

  iterative_magnitude_comparator #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt)
  );

  typedef struct {
    int         acc;
    int         dn;
    logic [2:0] res;
  } exp_t;

  exp_t       sb [$];
  int         cyc      = 0;
  int         next_ok  = 0;
  int         checks   = 0;
  int         failures = 0;
  logic [2:0] last_res = 3'b000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference verdict {gt,eq,lt} straight from numeric comparison.
  function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                         input logic sg);
    if (sg) begin
      if ($signed(av) > $signed(bv)) return 3'b100;
      if ($signed(av) < $signed(bv)) return 3'b001;
      return 3'b010;
    end
    if (av > bv) return 3'b100;
    if (av < bv) return 3'b001;
    return 3'b010;
  endfunction

  // Reference latency in cycles from the accepting edge to the done edge.
  function automatic int ref_lat(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
`ifdef CMP_EARLY_EXIT_EN
    for (int k = NDIG - 1; k >= 0; k--) begin
      if (((av >> (k * DIGIT)) & 32'hF) != ((bv >> (k * DIGIT)) & 32'hF)) return NDIG - k;
    end
    return NDIG;
`else
    return NDIG;
`endif
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs (called at a negedge); record an expectation if accepted.
  task automatic step(input logic st, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic sg);
    exp_t e;
    start     = st;
    a         = av;
    b         = bv;
    is_signed = sg;
    if (st && (cyc + 1 >= next_ok)) begin
      e.acc   = cyc + 1;
      e.dn    = e.acc + ref_lat(av, bv);
      e.res   = ref_cmp(av, bv, sg);
      next_ok = e.dn + 1;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom, 1'($urandom));
  endtask

  task automatic wait_idle();
    while (cyc + 1 < next_ok) step(1'b0, $urandom, $urandom, 1'($urandom));
  endtask

  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sg);
    wait_idle();
    step(1'b1, av, bv, sg);
    step(1'b0, av, bv, sg);
  endtask

  task automatic rand_operands(output logic [WIDTH-1:0] av, output logic [WIDTH-1:0] bv);
    logic [WIDTH-1:0] edge_vals [4];
    int               k;
    edge_vals[0] = 32'h0000_0000;
    edge_vals[1] = 32'hFFFF_FFFF;
    edge_vals[2] = 32'h8000_0000;
    edge_vals[3] = 32'h7FFF_FFFF;
    av = $urandom;
    bv = $urandom;
    case ($urandom_range(0, 3))
      0: ;
      1: bv = av;
      2: begin
        k  = $urandom_range(0, NDIG - 1);
        bv = av ^ (32'($urandom_range(1, 15)) << (k * DIGIT));
      end
      default: begin
        av = edge_vals[$urandom_range(0, 3)];
        bv = edge_vals[$urandom_range(0, 3)];
      end
    endcase
  endtask

  // Monitor: every cycle compare busy/done and the result bus against the scoreboard.
  initial begin
    exp_t e;
    logic exp_busy, exp_done;
    forever begin
      @(posedge clk);
      #1;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      if (sb.size() > 0) begin
        exp_busy = (cyc >= sb[0].acc) && (cyc < sb[0].dn);
        exp_done = (cyc == sb[0].dn);
      end
      chk("busy", {2'b00, busy}, {2'b00, exp_busy});
      chk("done", {2'b00, done}, {2'b00, exp_done});
      if (done && exp_done) begin
        e = sb.pop_front();
        chk("result", {gt, eq, lt}, e.res);
        last_res = e.res;
      end else begin
        chk("hold", {gt, eq, lt}, last_res);
      end
      if (sb.size() > 0 && cyc > sb[0].dn) begin
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL done_timeout at cycle %0d: got no done expected done at cycle %0d", cyc, e.dn);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog at time %0t: got no finish expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, gt}, 3'b000);
    chk("reset_eq_lt", {1'b0, eq, lt}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);

    // Equal operands, full latency.
    run_op(32'h1234_5678, 32'h1234_5678, 1'b0);
    // Sign handling on the MSB digit.
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    // Difference in the top digit (early-exit boundary) and in the bottom digit.
    run_op(32'hF000_0000, 32'h0000_0000, 1'b0);
    run_op(32'h0000_0003, 32'h0000_0004, 1'b0);

    // A second start during RUN is ignored.
    wait_idle();
    step(1'b1, 32'd5, 32'd9, 1'b0);
    step(1'b0, 32'd5, 32'd9, 1'b0);
    step(1'b0, 32'd5, 32'd9, 1'b0);
    step(1'b1, 32'd9, 32'd5, 1'b1);
    step(1'b0, 32'd9, 32'd5, 1'b0);

    // Reset in the middle of a run aborts it without a done pulse.
    wait_idle();
    step(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0);
    idle_cycles(3);
    rst_n = 1'b0;
    sb.delete();
    last_res = 3'b000;
    next_ok  = 0;
    #1;
    chk("midrun_reset_bd", {1'b0, busy, done}, 3'b000);
    chk("midrun_reset_res", {gt, eq, lt}, 3'b000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'hFFFF_FFF0, 32'h0000_0010, 1'b1);

    // Start held high with changing operands: back-to-back accepts.
    wait_idle();
    for (int i = 0; i < 40; i++) begin
      rand_operands(ra, rb);
      step(1'b1, ra, rb, 1'($urandom));
    end
    step(1'b0, '0, '0, 1'b0);

    // Randomized traffic with random gaps and occasional stray starts.
    for (int i = 0; i < 60; i++) begin
      rand_operands(ra, rb);
      wait_idle();
      idle_cycles($urandom_range(0, 2));
      step(1'b1, ra, rb, 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        rand_operands(ra, rb);
        step(1'b1, ra, rb, 1'($urandom));
      end
    end

    wait_idle();
    idle_cycles(3);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d outstanding expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
